// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one instruction read at a time and queues
// returned {pc, instr} pairs in a small circular buffer for the decoder.
module instr_fetch #(
  parameter int AddrWidth  = 32,
  parameter int InstrWidth = 32,
  parameter int QueueDepth = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [AddrWidth-1:0]  pc_in,
  output logic                  if_to_pc_en_out,
  input  logic                  commit_to_if_flush_in,
  output logic                  if_to_mem_req_out,
  output logic [AddrWidth-1:0]  if_to_mem_addr_out,
  input  logic                  mem_to_if_valid_in,
  input  logic [InstrWidth-1:0] mem_to_if_data_in,
  output logic                  if_to_dec_valid_out,
  output logic [InstrWidth-1:0] if_to_dec_instr_out,
  output logic [AddrWidth-1:0]  if_to_dec_pc_out,
  input  logic                  dec_to_if_ready_in
);

  localparam int PtrWidth = $clog2(QueueDepth);
  localparam int CntWidth = PtrWidth + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                state;
  state_t                next_state;
  logic [AddrWidth-1:0]  addr;
  logic [PtrWidth-1:0]   head;
  logic [PtrWidth-1:0]   tail;
  logic [CntWidth-1:0]   count;
  logic [InstrWidth-1:0] instr_q [QueueDepth];
  logic [AddrWidth-1:0]  pc_q    [QueueDepth];

  logic flush;
  logic push;
  logic pop;
  logic issue;

  assign flush = commit_to_if_flush_in;
  assign push  = rdy_in && (state == WAIT) && mem_to_if_valid_in && !flush;
  assign pop   = rdy_in && (count != '0) && dec_to_if_ready_in && !flush;
  assign issue = rdy_in && (state == IDLE) && !flush && (count < CntWidth'(QueueDepth));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A flush during an outstanding read cannot cancel it, so the reply is
  // still awaited in DROP and thrown away when it arrives.
  always_comb begin
    next_state = state;
    if (rdy_in) begin
      case (state)
        IDLE: if (issue) next_state = WAIT;
        WAIT: begin
          if (mem_to_if_valid_in) begin
            next_state = IDLE;
          end else if (flush) begin
            next_state = DROP;
          end
        end
        DROP: if (mem_to_if_valid_in) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks out
  // of a half-finished read during the reset cycle itself.
  always_comb begin
    if_to_mem_req_out   = !rst_in && (state != IDLE);
    if_to_mem_addr_out  = rst_in ? '0 : addr;
    if_to_pc_en_out     = !rst_in && push;
    if_to_dec_valid_out = !rst_in && (count != '0);
    if_to_dec_instr_out = instr_q[head];
    if_to_dec_pc_out    = pc_q[head];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (rdy_in) begin
      if (issue) begin
        addr <= pc_in;
      end
      if (flush) begin
        head  <= tail;
        count <= '0;
      end else begin
        if (push) begin
          tail <= tail + PtrWidth'(1);
        end
        if (pop) begin
          head <= head + PtrWidth'(1);
        end
        case ({push, pop})
          2'b10:   count <= count + CntWidth'(1);
          2'b01:   count <= count - CntWidth'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      instr_q[tail] <= mem_to_if_data_in;
      pc_q[tail]    <= addr;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a transaction-level model (queue of
// {pc, instr}, pending/stale read flags) is compared against the DUT every cycle.
module tb_instr_fetch;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int QD = 4;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } ent_t;

  logic          clk_in    = 1'b0;
  logic          rst_in    = 1'b1;
  logic          rdy_in    = 1'b0;
  logic          flush     = 1'b0;
  logic          dec_ready = 1'b0;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] pc_in     = '0;
  logic [IW-1:0] mem_data  = '0;
  logic          pc_en;
  logic          mem_req;
  logic          dec_valid;
  logic [AW-1:0] mem_addr;
  logic [AW-1:0] dec_pc;
  logic [IW-1:0] dec_instr;

  int checks = 0;
  int errors = 0;

  ent_t          mq[$];
  ent_t          got[$];
  bit            m_pend  = 1'b0;
  bit            m_stale = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [AW-1:0] pc_reg  = '0;
  logic          exp_pc_en;
  int            mem_lat = 0;
  int            mem_cnt = 0;
  int            pulses  = 0;
  bit            found;

  always #5 clk_in = ~clk_in;

  instr_fetch #(
    .AddrWidth (AW),
    .InstrWidth(IW),
    .QueueDepth(QD)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .pc_in                (pc_in),
    .if_to_pc_en_out      (pc_en),
    .commit_to_if_flush_in(flush),
    .if_to_mem_req_out    (mem_req),
    .if_to_mem_addr_out   (mem_addr),
    .mem_to_if_valid_in   (mem_valid),
    .mem_to_if_data_in    (mem_data),
    .if_to_dec_valid_out  (dec_valid),
    .if_to_dec_instr_out  (dec_instr),
    .if_to_dec_pc_out     (dec_pc),
    .dec_to_if_ready_in   (dec_ready)
  );

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1300_0000 + a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_output();
    exp_pc_en = !rst_in && rdy_in && m_pend && !m_stale && mem_valid && !flush;
    check("mem_req", 64'(mem_req), 64'(!rst_in && m_pend));
    check("mem_addr", 64'(mem_addr), rst_in ? 64'(0) : 64'(m_addr));
    check("pc_en", 64'(pc_en), 64'(exp_pc_en));
    check("dec_valid", 64'(dec_valid), 64'(!rst_in && mq.size() != 0));
    if (!rst_in && mq.size() != 0) begin
      check("dec_pc", 64'(dec_pc), 64'(mq[0].pc));
      check("dec_instr", 64'(dec_instr), 64'(mq[0].instr));
    end
  endtask

  // One clock cycle: drive inputs, let the memory responder react, compare,
  // then advance the model, the PC block and the memory as of the next edge.
  task automatic apply_stimulus(input logic rst, input logic rdy, input logic fl,
                                input logic rd, input logic [AW-1:0] target);
    int pre_size;
    bit pre_pend;
    @(negedge clk_in);
    rst_in    = rst;
    rdy_in    = rdy;
    flush     = fl;
    dec_ready = rd;
    pc_in     = pc_reg;
    #1;
    mem_valid = 1'b0;
    mem_data  = $urandom;
    if (rst) begin
      mem_cnt = 0;
    end else if (mem_req) begin
      if (mem_cnt >= mem_lat) begin
        mem_valid = 1'b1;
        mem_data  = mem_word(mem_addr);
        mem_cnt   = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    #1;
    check_output();
    if (pc_en) pulses++;
    if (!rst && rdy && !fl && rd && dec_valid) begin
      got.push_back(ent_t'{pc: dec_pc, instr: dec_instr});
    end
    pre_size = mq.size();
    pre_pend = m_pend;
    if (rst) begin
      mq.delete();
      m_pend  = 1'b0;
      m_stale = 1'b0;
      m_addr  = '0;
      pc_reg  = '0;
    end else if (rdy) begin
      if (fl) begin
        mq.delete();
        if (m_pend && mem_valid) begin
          m_pend  = 1'b0;
          m_stale = 1'b0;
        end else if (m_pend) begin
          m_stale = 1'b1;
        end
        pc_reg = target;
      end else begin
        if (rd && pre_size > 0) void'(mq.pop_front());
        if (m_pend && mem_valid) begin
          if (!m_stale) mq.push_back(ent_t'{pc: m_addr, instr: mem_word(m_addr)});
          m_pend  = 1'b0;
          m_stale = 1'b0;
        end
        if (exp_pc_en) pc_reg = pc_reg + 32'd4;
        if (!pre_pend && pre_size < QD) begin
          m_pend = 1'b1;
          m_addr = pc_in;
        end
      end
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    got.delete();
    pulses = 0;
  endtask

  initial begin
    int base;
    mem_lat = 0;
    do_reset();
    do_reset();
    check("reset_req", 64'(mem_req), 64'(0));
    check("reset_valid", 64'(dec_valid), 64'(0));

    $display("[TB] straight-line fetch");
    mem_lat = 0;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("sl_pulses", 64'(pulses), 64'(3));
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("sl_count", 64'(got.size()), 64'(3));
    if (got.size() >= 3) begin
      check("sl_pc0", 64'(got[0].pc), 64'h0);
      check("sl_i0", 64'(got[0].instr), 64'h1300_0000);
      check("sl_pc1", 64'(got[1].pc), 64'h4);
      check("sl_i1", 64'(got[1].instr), 64'h1300_0004);
      check("sl_pc2", 64'(got[2].pc), 64'h8);
      check("sl_i2", 64'(got[2].instr), 64'h1300_0008);
    end

    $display("[TB] backpressure");
    do_reset();
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("bp_pulses", 64'(pulses), 64'(4));
    check("bp_req_full", 64'(mem_req), 64'(0));
    check("bp_head_pc", 64'(dec_pc), 64'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("bp_req_next", 64'(mem_req), 64'(1));
    check("bp_addr_next", 64'(mem_addr), 64'h10);
    for (int i = 0; i < 2; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("bp_pulses2", 64'(pulses), 64'(5));
    check("bp_req_refull", 64'(mem_req), 64'(0));
    check("bp_popped", 64'(got.size()), 64'(1));

    $display("[TB] flush while waiting");
    do_reset();
    mem_lat = 0;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'hC);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    mem_lat = 3;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    base = pulses;
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    check("fw_addr", 64'(mem_addr), 64'h10);
    check("fw_queued", 64'(dec_valid), 64'(1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("fw_empty", 64'(dec_valid), 64'(0));
    check("fw_drop_req", 64'(mem_req), 64'(1));
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
      if (mem_req && mem_addr == 32'h100) found = 1'b1;
    end
    check("fw_new_addr", 64'(found), 64'(1));
    check("fw_no_pc_en", 64'(pulses - base), 64'(0));

    $display("[TB] flush coincident with valid");
    do_reset();
    mem_lat = 0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h40);
    check("fc_pc_en", 64'(pc_en), 64'(0));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("fc_valid", 64'(dec_valid), 64'(0));
    check("fc_idle", 64'(mem_req), 64'(0));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, '0);
    check("fc_target", 64'(mem_addr), 64'h40);

    $display("[TB] wrap-around");
    do_reset();
    mem_lat = 0;
    for (int c = 0; c < 200 && got.size() < 10; c++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, logic'(c % 2), '0);
    end
    check("wrap_count", 64'(got.size() >= 10), 64'(1));
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      check("wrap_pc", 64'(got[i].pc), 64'(4 * i));
      check("wrap_instr", 64'(got[i].instr), 64'(32'h1300_0000 + 4 * i));
    end

    $display("[TB] stall and reset mid-read");
    do_reset();
    mem_lat = 2;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("st_req_held", 64'(mem_req), 64'(1));
    end
    check("st_no_pulse", 64'(pulses), 64'(0));
    check("st_empty", 64'(dec_valid), 64'(0));
    for (int i = 0; i < 10 && pulses == 0; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("st_resumed", 64'(pulses), 64'(1));
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("rs_waiting", 64'(mem_req), 64'(1));
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rs_req", 64'(mem_req), 64'(0));
    check("rs_addr", 64'(mem_addr), 64'(0));
    check("rs_valid", 64'(dec_valid), 64'(0));
    check("rs_pc_en", 64'(pc_en), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
